// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: data width, memory
// address width, funct3 size codes, FSM states and small decode helpers.
package lsu_mem_ctrl_pkg;

    localparam int dw         = 64;
    localparam int MEM_ADDR_W = 16;

    // RV64I funct3 size/sign codes; 3'b111 is never a legal access
    typedef enum logic [2:0] {
        F3_B   = 3'b000,
        F3_H   = 3'b001,
        F3_W   = 3'b010,
        F3_D   = 3'b011,
        F3_BU  = 3'b100,
        F3_HU  = 3'b101,
        F3_WU  = 3'b110,
        F3_BAD = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Low-aligned byte mask for an access size (funct3[1:0])
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Stores only allow SB/SH/SW/SD; loads reject only 3'b111
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = f3[2];
        end else begin
            bad = (f3 == 3'b111);
        end
        return bad;
    endfunction

    // Address not a multiple of the access size
    function automatic logic addr_misaligned(input logic [1:0] sz, input logic [2:0] lo);
        logic mis;
        case (sz)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lo[0];
            2'b10:   mis = |lo[1:0];
            default: mis = |lo[2:0];
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake bundle between the MEM stage (master) and the
// load/store controller (slave).
interface lsu_mem_ctrl_if;
    import lsu_mem_ctrl_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [63:0]     req_addr;
    logic [dw-1:0]   req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [dw-1:0]   resp_rdata;
    logic            resp_fault;
    logic            resp_misaligned;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault, resp_misaligned
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault, resp_misaligned
    );

endinterface

// File: rtl/lsu_mem_ctrl_load_ext.sv
// lsu_load_ext: picks the low 1/2/4/8 bytes of the raw memory word and
// sign- or zero-extends them according to funct3.
module lsu_load_ext
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]    funct3,
    input  logic [dw-1:0] raw,
    output logic [dw-1:0] data
);

    // Size/sign selection of the loaded value
    always_comb begin
        data = {dw{1'b0}};
        case (funct3_e'(funct3))
            F3_B:    data = {{56{raw[7]}},  raw[7:0]};
            F3_H:    data = {{48{raw[15]}}, raw[15:0]};
            F3_W:    data = {{32{raw[31]}}, raw[31:0]};
            F3_D:    data = raw;
            F3_BU:   data = {56'h0, raw[7:0]};
            F3_HU:   data = {48'h0, raw[15:0]};
            F3_WU:   data = {32'h0, raw[31:0]};
            default: data = {dw{1'b0}};
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time load/store controller in front of the 64 KiB
// byte-addressable data memory. IDLE -> ACCESS -> RESP per transaction.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap accesses not aligned
// to their size instead of performing them byte-granular).
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    lsu_mem_ctrl_if.slave         bus,
    output logic [7:0]            mem_w_mask,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [dw-1:0]         mem_write_data,
    input  logic [dw-1:0]         mem_read_data
);

    state_e                  state_r;
    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic [dw-1:0]           resp_rdata_r;
    logic                    resp_fault_r;
    logic                    resp_mis_r;
    logic [7:0]              mask_r;
    logic [MEM_ADDR_W-1:0]   addr_r;
    logic [dw-1:0]           wdata_r;
    logic                    we_r;
    logic [2:0]              f3_r;
    logic                    fault_r;
    logic                    mis_r;

    logic                    fault_s;
    logic                    mis_s;
    logic [dw-1:0]           ext_s;

    // Classify the incoming request: out-of-range/illegal and misalignment
    always_comb begin
        fault_s = (|bus.req_addr[63:MEM_ADDR_W]) ||
                  funct3_illegal(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_s = addr_misaligned(bus.req_funct3[1:0], bus.req_addr[2:0]);
`else
        mis_s = 1'b0;
`endif
    end

    lsu_load_ext u_load_ext (
        .funct3 (f3_r),
        .raw    (mem_read_data),
        .data   (ext_s)
    );

    // Transaction FSM; every output is a register so a reset mid-ACCESS
    // drops the write mask immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {dw{1'b0}};
            resp_fault_r <= 1'b0;
            resp_mis_r   <= 1'b0;
            mask_r       <= 8'h00;
            addr_r       <= {MEM_ADDR_W{1'b0}};
            wdata_r      <= {dw{1'b0}};
            we_r         <= 1'b0;
            f3_r         <= 3'b000;
            fault_r      <= 1'b0;
            mis_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_r        <= bus.req_we;
                        f3_r        <= bus.req_funct3;
                        addr_r      <= bus.req_addr[MEM_ADDR_W-1:0];
                        wdata_r     <= bus.req_wdata;
                        fault_r     <= fault_s;
                        mis_r       <= mis_s;
                        mask_r      <= (bus.req_we && !fault_s && !mis_s) ?
                                       size_mask(bus.req_funct3[1:0]) : 8'h00;
                        req_ready_r <= 1'b0;
                        state_r     <= ACCESS;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                ACCESS: begin
                    mask_r       <= 8'h00;
                    resp_valid_r <= 1'b1;
                    resp_rdata_r <= (!we_r && !fault_r && !mis_r) ? ext_s : {dw{1'b0}};
                    resp_fault_r <= fault_r;
                    resp_mis_r   <= mis_r;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end else begin
                        state_r      <= RESP;
                    end
                end
                default: begin
                    mask_r       <= 8'h00;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_rdata      = resp_rdata_r;
    assign bus.resp_fault      = resp_fault_r;
    assign bus.resp_misaligned = resp_mis_r;
    assign mem_w_mask          = mask_r;
    assign mem_address         = addr_r;
    assign mem_write_data      = wdata_r;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a behavioural 64 KiB
// byte memory (combinational read of 8 bytes, 16-bit address wrap).
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [7:0]            mem_w_mask;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [dw-1:0]         mem_write_data;
    logic [dw-1:0]         mem_read_data;
    logic [7:0]            mem [0:65535] = '{default: 8'h00};

    int checks   = 0;
    int failures = 0;

    // results of the last transaction
    logic [7:0]    acc_mask, resp_mask;
    logic [15:0]   acc_addr;
    logic          acc_rv, acc_rr, done_rv, done_rr;
    logic [63:0]   r_rdata;
    logic          r_fault, r_mis;
    int            lat;
    logic [63:0]   held;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus.slave),
        .mem_w_mask     (mem_w_mask),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) mem_read_data[i*8 +: 8] = mem[mem_address + 16'(i)];
    end

    always @(posedge clk) begin
        for (int j = 0; j < 8; j++)
            if (mem_w_mask[j]) mem[mem_address + 16'(j)] <= mem_write_data[j*8 +: 8];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction with resp_ready already high before resp_valid
    task automatic run(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wd);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd; bus.resp_ready = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        acc_mask = mem_w_mask; acc_addr = mem_address;
        acc_rv = bus.resp_valid; acc_rr = bus.req_ready;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (bus.resp_valid !== 1'b1 && n < 20);
        lat = n;
        resp_mask = mem_w_mask; r_rdata = bus.resp_rdata;
        r_fault = bus.resp_fault; r_mis = bus.resp_misaligned;
        @(posedge clk); #1;
        done_rv = bus.resp_valid; done_rr = bus.req_ready;
        bus.resp_ready = 1'b0;
        chk("latency", 64'(lat), 64'd1);
        chk("access_resp_valid", {63'd0, acc_rv}, 64'd0);
        chk("access_req_ready", {63'd0, acc_rr}, 64'd0);
        chk("resp_mask", {56'd0, resp_mask}, 64'd0);
        chk("done_resp_valid", {63'd0, done_rv}, 64'd0);
        chk("done_req_ready", {63'd0, done_rr}, 64'd1);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
        bus.req_addr = 64'd0; bus.req_wdata = 64'd0; bus.resp_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_rdata", bus.resp_rdata, 64'd0);
        chk("rst_fault", {63'd0, bus.resp_fault}, 64'd0);
        chk("rst_mis", {63'd0, bus.resp_misaligned}, 64'd0);
        chk("rst_mask", {56'd0, mem_w_mask}, 64'd0);
        chk("rst_addr", {48'd0, mem_address}, 64'd0);
        chk("rst_wdata", mem_write_data, 64'd0);
        @(negedge clk) rst = 1'b0;

        // SD / LD round trip
        run(1'b1, 3'b011, 64'h0100, 64'h1122334455667788);
        chk("sd_mask", {56'd0, acc_mask}, 64'hFF);
        chk("sd_addr", {48'd0, acc_addr}, 64'h0100);
        chk("sd_rdata", r_rdata, 64'd0);
        chk("sd_flags", {62'd0, r_fault, r_mis}, 64'd0);
        run(1'b0, 3'b011, 64'h0100, 64'd0);
        chk("ld_mask", {56'd0, acc_mask}, 64'h00);
        chk("ld_rdata", r_rdata, 64'h1122334455667788);
        chk("ld_flags", {62'd0, r_fault, r_mis}, 64'd0);

        // byte store, signed/unsigned byte loads
        run(1'b1, 3'b000, 64'h0203, 64'hAAAAAAAAAAAAAA80);
        chk("sb_mask", {56'd0, acc_mask}, 64'h01);
        chk("sb_byte", {56'd0, mem[16'h0203]}, 64'h80);
        chk("sb_next_byte", {56'd0, mem[16'h0204]}, 64'h00);
        run(1'b0, 3'b000, 64'h0203, 64'd0);
        chk("lb_rdata", r_rdata, 64'hFFFFFFFFFFFFFF80);
        run(1'b0, 3'b100, 64'h0203, 64'd0);
        chk("lbu_rdata", r_rdata, 64'h0000000000000080);

        // word/half extension
        run(1'b1, 3'b011, 64'h0300, 64'hF0E0D0C0B0A09080);
        run(1'b0, 3'b010, 64'h0300, 64'd0);
        chk("lw_neg", r_rdata, 64'hFFFFFFFFB0A09080);
        run(1'b0, 3'b110, 64'h0300, 64'd0);
        chk("lwu", r_rdata, 64'h00000000B0A09080);
        run(1'b0, 3'b001, 64'h0304, 64'd0);
        chk("lh_neg", r_rdata, 64'hFFFFFFFFFFFFD0C0);
        run(1'b0, 3'b101, 64'h0304, 64'd0);
        chk("lhu", r_rdata, 64'h000000000000D0C0);
        run(1'b0, 3'b010, 64'h0100, 64'd0);
        chk("lw_pos", r_rdata, 64'h0000000055667788);

        // out-of-range accesses
        run(1'b0, 3'b010, 64'h0001_0000, 64'd0);
        chk("oor_ld_fault", {63'd0, r_fault}, 64'd1);
        chk("oor_ld_rdata", r_rdata, 64'd0);
        run(1'b1, 3'b010, 64'h0001_0000, 64'h00000000CAFEBABE);
        chk("oor_st_mask", {56'd0, acc_mask}, 64'h00);
        chk("oor_st_fault", {63'd0, r_fault}, 64'd1);
        chk("oor_st_mem", {48'd0, mem[16'h0001], mem[16'h0000]}, 64'd0);

        // illegal funct3
        run(1'b0, 3'b111, 64'h0100, 64'd0);
        chk("ill_ld_fault", {63'd0, r_fault}, 64'd1);
        chk("ill_ld_rdata", r_rdata, 64'd0);
        run(1'b1, 3'b101, 64'h0400, 64'hFFFFFFFFFFFFFFFF);
        chk("ill_st_mask", {56'd0, acc_mask}, 64'h00);
        chk("ill_st_fault", {63'd0, r_fault}, 64'd1);
        chk("ill_st_mem", {56'd0, mem[16'h0400]}, 64'd0);

        // misaligned word store
        run(1'b1, 3'b010, 64'h0102, 64'h00000000DEADBEEF);
        chk("mis_sw_flag", {63'd0, r_mis}, TRAP ? 64'd1 : 64'd0);
        chk("mis_sw_mask", {56'd0, acc_mask}, TRAP ? 64'h00 : 64'h0F);
        run(1'b0, 3'b011, 64'h0100, 64'd0);
        chk("mis_sw_readback", r_rdata, TRAP ? 64'h1122334455667788 : 64'h1122DEADBEEF7788);

        // 16-bit address wrap
        run(1'b1, 3'b011, 64'hFFFC, 64'h0807060504030201);
        chk("wrap_mask", {56'd0, acc_mask}, TRAP ? 64'h00 : 64'hFF);
        chk("wrap_hi", {56'd0, mem[16'hFFFC]}, TRAP ? 64'h00 : 64'h01);
        chk("wrap_lo", {48'd0, mem[16'h0003], mem[16'h0000]}, TRAP ? 64'h0 : 64'h0805);

        // stall in RESP with a new request pending
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b011;
        bus.req_addr = 64'h0300; bus.req_wdata = 64'd0; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        bus.req_funct3 = 3'b100;
        @(posedge clk); #1;
        held = bus.resp_rdata;
        chk("stall_first", held, 64'hF0E0D0C0B0A09080);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", {63'd0, bus.resp_valid}, 64'd1);
            chk("stall_rdata", bus.resp_rdata, 64'hF0E0D0C0B0A09080);
            chk("stall_req_ready", {63'd0, bus.req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_rv", {63'd0, bus.resp_valid}, 64'd0);
        chk("stall_release_rr", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("pending_accepted", {63'd0, bus.req_ready}, 64'd0);
        @(posedge clk); #1;
        chk("pending_valid", {63'd0, bus.resp_valid}, 64'd1);
        chk("pending_rdata", bus.resp_rdata, 64'h80);
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;

        // reset during ACCESS of a store
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b011;
        bus.req_addr = 64'h0500; bus.req_wdata = 64'hFFFFFFFFFFFFFFFF; bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rstacc_mask_before", {56'd0, mem_w_mask}, 64'hFF);
        #1 rst = 1'b1;
        #1;
        chk("rstacc_mask_async", {56'd0, mem_w_mask}, 64'h00);
        chk("rstacc_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_mem", {mem[16'h0507], mem[16'h0506], mem[16'h0505], mem[16'h0504],
                           mem[16'h0503], mem[16'h0502], mem[16'h0501], mem[16'h0500]}, 64'd0);
        chk("rstacc_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rstacc_resp_valid_after", {63'd0, bus.resp_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
